// File: rtl/fetch_unit.sv
// -----------------------------------------------------------------------------
// fetch_unit
//   Instruction fetch stage sitting directly behind the 64-byte instruction
//   cache. Owns the PC, issues one fetch per cycle on a hit, and hands the
//   cache's registered word plus its PC to decode through a valid/ready
//   handshake backed by a 1-entry skid buffer. Handles branch redirects
//   (deferred while a refill is in progress), halt, and a global clock enable.
//
//   Optional feature: define FETCH_PERF_EN to add the performance counters
//   perf_fetched, perf_miss_cycles and perf_redirects.
//
// Ports:
//   clk, rst        clock, asynchronous active-high reset
//   clk_en          global clock enable; all state holds when low
//   redirect        one-cycle taken-branch pulse, target on redirect_pc
//   halt            level; stop issuing fetches while high
//   ic_req/ic_addr  fetch request and address to the cache
//   ic_inst         cache registered output for last cycle's accepted address
//   ic_busy         cache refill in progress
//   out_valid/out_inst/out_pc/out_ready   handshake to decode
//   perf_*          (FETCH_PERF_EN only) event counters, wrap at full scale
// -----------------------------------------------------------------------------
module fetch_unit #(
    parameter int                PC_W     = 10,
    parameter int                INST_W   = 16,
    parameter logic [PC_W-1:0]   RESET_PC = '0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              clk_en,
    input  logic              redirect,
    input  logic [PC_W-1:0]   redirect_pc,
    input  logic              halt,
    output logic              ic_req,
    output logic [PC_W-1:0]   ic_addr,
    input  logic [INST_W-1:0] ic_inst,
    input  logic              ic_busy,
    output logic              out_valid,
    output logic [INST_W-1:0] out_inst,
    output logic [PC_W-1:0]   out_pc,
    input  logic              out_ready
`ifdef FETCH_PERF_EN
    ,
    output logic [31:0]       perf_fetched,
    output logic [31:0]       perf_miss_cycles,
    output logic [15:0]       perf_redirects
`endif
);

    typedef enum logic [1:0] {
        S_RUN        = 2'd0,
        S_REDIR_WAIT = 2'd1,
        S_HALTED     = 2'd2
    } state_t;

    // Control state (asynchronously reset)
    state_t            state_q, state_d;
    logic [PC_W-1:0]   fetch_pc_q, fetch_pc_d;
    logic [PC_W-1:0]   pend_pc_q, pend_pc_d;
    logic              resp_valid_q, resp_valid_d;
    logic              hold_valid_q, hold_valid_d;
    // Datapath state (no reset; qualified by the valid flags above)
    logic [PC_W-1:0]   resp_pc_q, resp_pc_d;
    logic [PC_W-1:0]   hold_pc_q, hold_pc_d;
    logic [INST_W-1:0] hold_inst_q, hold_inst_d;

    logic              out_valid_raw;
    logic              accept;

    always_comb begin
        state_d      = state_q;
        fetch_pc_d   = fetch_pc_q;
        pend_pc_d    = pend_pc_q;
        resp_valid_d = resp_valid_q;
        hold_valid_d = hold_valid_q;
        resp_pc_d    = resp_pc_q;
        hold_pc_d    = hold_pc_q;
        hold_inst_d  = hold_inst_q;

        // A redirect squashes whatever is on the output in the same cycle.
        out_valid_raw = (hold_valid_q | resp_valid_q) & ~redirect & (state_q != S_REDIR_WAIT);

        accept = clk_en & (state_q == S_RUN) & ~ic_busy & ~redirect & ~halt
                 & (out_ready | ~out_valid_raw);

        if (clk_en) begin
            // The cache word is only valid in the cycle after an accept.
            resp_valid_d = accept;
            if (accept) begin
                resp_pc_d  = fetch_pc_q;
                fetch_pc_d = fetch_pc_q + PC_W'(1);
            end

            if (out_ready) begin
                hold_valid_d = 1'b0;
            end
            // Park the cache word when decode stalls; the cache will not hold it.
            if (resp_valid_q && !out_ready && !redirect) begin
                hold_valid_d = 1'b1;
                hold_inst_d  = ic_inst;
                hold_pc_d    = resp_pc_q;
            end

            if (redirect) begin
                resp_valid_d = 1'b0;
                hold_valid_d = 1'b0;
                if (!ic_busy) begin
                    fetch_pc_d = redirect_pc;
                    if (state_q == S_REDIR_WAIT) begin
                        state_d = halt ? S_HALTED : S_RUN;
                    end
                end else begin
                    // ic_addr must not move during a refill; remember the newest target.
                    pend_pc_d = redirect_pc;
                    state_d   = S_REDIR_WAIT;
                end
            end else begin
                unique case (state_q)
                    S_RUN: begin
                        if (halt && !ic_busy) begin
                            state_d = S_HALTED;
                        end
                    end
                    S_HALTED: begin
                        if (!halt) begin
                            state_d = S_RUN;
                        end
                    end
                    S_REDIR_WAIT: begin
                        if (!ic_busy) begin
                            fetch_pc_d = pend_pc_q;
                            state_d    = halt ? S_HALTED : S_RUN;
                        end
                    end
                    default: state_d = S_RUN;
                endcase
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= S_RUN;
            fetch_pc_q   <= RESET_PC;
            pend_pc_q    <= '0;
            resp_valid_q <= 1'b0;
            hold_valid_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            fetch_pc_q   <= fetch_pc_d;
            pend_pc_q    <= pend_pc_d;
            resp_valid_q <= resp_valid_d;
            hold_valid_q <= hold_valid_d;
        end
    end

    always_ff @(posedge clk) begin
        resp_pc_q   <= resp_pc_d;
        hold_pc_q   <= hold_pc_d;
        hold_inst_q <= hold_inst_d;
    end

    assign ic_addr   = fetch_pc_q;
    assign ic_req    = ~rst & (state_q != S_HALTED);
    assign out_valid = ~rst & out_valid_raw;
    assign out_inst  = rst ? '0 : (hold_valid_q ? hold_inst_q : ic_inst);
    assign out_pc    = rst ? '0 : (hold_valid_q ? hold_pc_q : resp_pc_q);

`ifdef FETCH_PERF_EN
    logic [31:0] perf_fetched_q;
    logic [31:0] perf_miss_cycles_q;
    logic [15:0] perf_redirects_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            perf_fetched_q     <= '0;
            perf_miss_cycles_q <= '0;
            perf_redirects_q   <= '0;
        end else if (clk_en) begin
            if (out_valid && out_ready) perf_fetched_q     <= perf_fetched_q + 32'd1;
            if (ic_busy)                perf_miss_cycles_q <= perf_miss_cycles_q + 32'd1;
            if (redirect)               perf_redirects_q   <= perf_redirects_q + 16'd1;
        end
    end

    assign perf_fetched     = perf_fetched_q;
    assign perf_miss_cycles = perf_miss_cycles_q;
    assign perf_redirects   = perf_redirects_q;
`endif

endmodule

// File: tb/tb_fetch_unit.sv
module tb_fetch_unit;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        clk_en = 1'b1;
    logic        redirect = 1'b0;
    logic [9:0]  redirect_pc = '0;
    logic        halt = 1'b0;
    logic        ic_req;
    logic [9:0]  ic_addr;
    logic [15:0] ic_inst = '0;
    logic        ic_busy = 1'b0;
    logic        out_valid;
    logic [15:0] out_inst;
    logic [9:0]  out_pc;
    logic        out_ready = 1'b1;
`ifdef FETCH_PERF_EN
    logic [31:0] perf_fetched;
    logic [31:0] perf_miss_cycles;
    logic [15:0] perf_redirects;
`endif

    int checks = 0;
    int errors = 0;
    int hs_cnt = 0;
    logic [9:0] exp_q[$];
    logic [9:0] mon_pc;

    fetch_unit #(.PC_W(10), .INST_W(16), .RESET_PC(10'd0)) dut (
        .clk(clk), .rst(rst), .clk_en(clk_en),
        .redirect(redirect), .redirect_pc(redirect_pc), .halt(halt),
        .ic_req(ic_req), .ic_addr(ic_addr), .ic_inst(ic_inst), .ic_busy(ic_busy),
        .out_valid(out_valid), .out_inst(out_inst), .out_pc(out_pc), .out_ready(out_ready)
`ifdef FETCH_PERF_EN
        , .perf_fetched(perf_fetched), .perf_miss_cycles(perf_miss_cycles),
        .perf_redirects(perf_redirects)
`endif
    );

    always #5 clk = ~clk;

    function automatic logic [15:0] inst_of(input logic [9:0] pc);
        return {6'h2A, pc};
    endfunction

    // Cache model: registered word for the address accepted on this edge.
    always @(posedge clk) begin
        if (clk_en && ic_req && !ic_busy) ic_inst <= inst_of(ic_addr);
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
        checks++;
        if (act !== expv) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, expv);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Scoreboard monitor: every handshake pops one expected PC.
    always @(negedge clk) begin
        if (rst) begin
            hs_cnt = 0;
        end else if (clk_en && out_valid && out_ready) begin
            hs_cnt++;
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL sb_unexpected actual_pc=%0h expected=none", out_pc);
            end else begin
                mon_pc = exp_q.pop_front();
                if (out_pc !== mon_pc || out_inst !== inst_of(mon_pc)) begin
                    errors++;
                    $display("FAIL sb_output actual=%0h/%0h expected=%0h/%0h",
                             out_pc, out_inst, mon_pc, inst_of(mon_pc));
                end
            end
        end
    end

    always @(negedge clk) begin
        if (!rst) begin
            checks++;
            if (dut.hold_valid_q && dut.resp_valid_q) begin
                errors++;
                $display("FAIL skid_invariant actual=both_valid expected=exclusive");
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog actual=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        // Reset outputs
        tick(); tick();
        chk("rst_ic_req", ic_req, 0);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_out_pc", out_pc, 0);
        chk("rst_out_inst", out_inst, 0);
        chk("rst_ic_addr", ic_addr, 0);

        // Streaming hits from reset
        for (int i = 0; i < 4; i++) exp_q.push_back(10'(i));
        rst = 1'b0;
        #1;
        chk("run_ic_req", ic_req, 1);
        for (int k = 1; k <= 4; k++) begin
            tick();
            chk("stream_valid", out_valid, 1);
            chk("stream_pc", out_pc, k - 1);
            chk("stream_lead", ic_addr, 32'(out_pc) + 1);
        end
        halt = 1'b1;
        tick();
        chk("halt_ic_req", ic_req, 0);
        chk("halt_drained", out_valid, 0);

        // Miss on first fetch after reset
        rst = 1'b1;
        #1;
        chk("async_rst_valid", out_valid, 0);
        tick();
        rst = 1'b0; halt = 1'b0; ic_busy = 1'b1;
        for (int i = 0; i < 7; i++) exp_q.push_back(10'(i));
        for (int k = 0; k < 17; k++) begin
            tick();
            chk("miss_addr_hold", ic_addr, 0);
            chk("miss_no_valid", out_valid, 0);
        end
        ic_busy = 1'b0;
        tick();
        chk("miss_first_pc", out_pc, 0);
        chk("miss_first_valid", out_valid, 1);
        for (int k = 2; k <= 6; k++) tick();
        chk("pre_stall_pc", out_pc, 5);

        // Decode stall: skid buffer holds PC 5
        out_ready = 1'b0;
        for (int k = 0; k < 3; k++) begin
            tick();
            chk("stall_pc", out_pc, 5);
            chk("stall_valid", out_valid, 1);
            chk("stall_addr", ic_addr, 6);
        end
        out_ready = 1'b1;
        tick();
        chk("after_stall_pc", out_pc, 6);
        tick();
        chk("pre_redir_pc", out_pc, 7);

        // Redirect on a hit squashes PC 7
        redirect = 1'b1; redirect_pc = 10'h200;
        #1;
        chk("redir_squash", out_valid, 0);
        tick();
        redirect = 1'b0;
        #1;
        chk("redir_gap", out_valid, 0);
        chk("redir_addr", ic_addr, 10'h200);
        exp_q.push_back(10'h200);
        exp_q.push_back(10'h201);
        tick();
        chk("redir_pc0", out_pc, 10'h200);
        tick();
        chk("redir_pc1", out_pc, 10'h201);
        halt = 1'b1;
        tick();
        chk("halt2_valid", out_valid, 0);

        // Redirects during a miss: newest target wins after refill
        redirect = 1'b1; redirect_pc = 10'h018;
        tick();
        redirect = 1'b0; halt = 1'b0;
        tick();
        chk("miss2_addr", ic_addr, 10'h018);
        chk("miss2_req", ic_req, 1);
        ic_busy = 1'b1;
        tick();
        redirect = 1'b1; redirect_pc = 10'h040;
        tick();
        redirect = 1'b0;
        tick();
        chk("rw_addr", ic_addr, 10'h018);
        chk("rw_valid", out_valid, 0);
        chk("rw_req", ic_req, 1);
        redirect = 1'b1; redirect_pc = 10'h080;
        tick();
        redirect = 1'b0;
        tick();
        chk("rw_addr2", ic_addr, 10'h018);
        ic_busy = 1'b0;
        tick();
        chk("rw_resolved_addr", ic_addr, 10'h080);
        exp_q.push_back(10'h080);
        exp_q.push_back(10'h081);
        tick();
        chk("rw_pc0", out_pc, 10'h080);
        tick();
        chk("rw_pc1", out_pc, 10'h081);
        halt = 1'b1;
        tick();
        chk("halt3_valid", out_valid, 0);

        // PC wrap and clock-enable hold
        redirect = 1'b1; redirect_pc = 10'h3FE;
        tick();
        redirect = 1'b0; halt = 1'b0;
        exp_q.push_back(10'h3FE);
        exp_q.push_back(10'h3FF);
        exp_q.push_back(10'h000);
        tick();
        tick();
        chk("wrap_pc0", out_pc, 10'h3FE);
        chk("wrap_addr0", ic_addr, 10'h3FF);
        clk_en = 1'b0;
        tick(); tick();
        chk("cen_pc", out_pc, 10'h3FE);
        chk("cen_valid", out_valid, 1);
        chk("cen_addr", ic_addr, 10'h3FF);
        clk_en = 1'b1;
        tick();
        chk("wrap_pc1", out_pc, 10'h3FF);
        chk("wrap_addr", ic_addr, 10'h000);
        tick();
        chk("wrap_pc2", out_pc, 10'h000);
        halt = 1'b1;
        tick();
        chk("final_req", ic_req, 0);
        chk("final_valid", out_valid, 0);
        tick();
        chk("sb_empty", exp_q.size(), 0);
`ifdef FETCH_PERF_EN
        chk("perf_fetched", perf_fetched, hs_cnt);
`endif
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
